// File: rtl/pool2_row_serializer.sv
// Accepts a four-word frame in one handshake and replays it one word per beat,
// with LEAD idle cycles before the first word and GAP idle cycles between words.
// Optional feature: define SER_IDX_EN to add the out_idx port.
module pool2_row_serializer #(
    parameter int DATA_W = 224,
    parameter int LEAD   = 0,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_word_1,
    input  logic [DATA_W-1:0] in_word_2,
    input  logic [DATA_W-1:0] in_word_3,
    input  logic [DATA_W-1:0] in_word_4,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done,
`ifdef SER_IDX_EN
    output logic [1:0]        out_idx,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [7:0] LEAD_CNT = (LEAD > 0) ? 8'(LEAD - 1) : 8'd0;
    localparam logic [7:0] GAP_CNT  = (GAP > 0)  ? 8'(GAP - 1)  : 8'd0;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        idx;
    logic [1:0]        idx_nxt;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic [DATA_W-1:0] word_buf [4];
    logic              load;
    logic              last_hs;

    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              last_nxt;
    logic              ready_nxt;
    logic              busy_nxt;
    logic [1:0]        oidx_nxt;
    logic [1:0]        oidx;

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                word_buf[i] <= '0;
            end
            in_ready   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            oidx       <= 2'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            if (load) begin
                word_buf[0] <= in_word_1;
                word_buf[1] <= in_word_2;
                word_buf[2] <= in_word_3;
                word_buf[3] <= in_word_4;
            end
            in_ready   <= ready_nxt;
            out_data   <= data_nxt;
            out_valid  <= valid_nxt;
            out_last   <= last_nxt;
            frame_done <= last_hs;
            busy       <= busy_nxt;
            oidx       <= oidx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        load      = 1'b0;
        last_hs   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    idx_nxt = 2'd0;
                    if (LEAD > 0) begin
                        state_nxt = ST_LEAD;
                        cnt_nxt   = LEAD_CNT;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            ST_LEAD, ST_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_SEND;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_SEND: begin
                if (out_valid && out_ready) begin
                    if (idx == 2'd3) begin
                        state_nxt = ST_IDLE;
                        last_hs   = 1'b1;
                    end else begin
                        idx_nxt = idx + 2'd1;
                        if (GAP > 0) begin
                            state_nxt = ST_GAP;
                            cnt_nxt   = GAP_CNT;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With LEAD=0 the first word goes out the cycle after loading, before word_buf holds it.
    always_comb begin
        valid_nxt = (state_nxt == ST_SEND);
        ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt  = (state_nxt != ST_IDLE);
        last_nxt  = valid_nxt && (idx_nxt == 2'd3);
        oidx_nxt  = valid_nxt ? idx_nxt : 2'd0;
        data_nxt  = '0;
        if (valid_nxt) begin
            data_nxt = load ? in_word_1 : word_buf[idx_nxt];
        end
    end

`ifdef SER_IDX_EN
    assign out_idx = oidx;
`else
    logic oidx_unused;
    assign oidx_unused = ^oidx;
`endif

endmodule

// File: tb/tb_pool2_row_serializer.sv
// Randomized bench for pool2_row_serializer: two instances (LEAD=0/GAP=2 and LEAD=4/GAP=0)
// checked every cycle against a frame-queue and timestamp reference model.
module tb_pool2_row_serializer;

    localparam int DW = 224;
    localparam int BW = DW + 7;
    localparam int LEAD_A = 0;
    localparam int GAP_A  = 2;
    localparam int LEAD_B = 4;
    localparam int GAP_B  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;

    logic          in_ready_a, out_valid_a, out_last_a, frame_done_a, busy_a;
    logic          in_ready_b, out_valid_b, out_last_b, frame_done_b, busy_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [1:0]    idx_a, idx_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool2_row_serializer #(.DATA_W(DW), .LEAD(LEAD_A), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst),
        .in_word_1(w1), .in_word_2(w2), .in_word_3(w3), .in_word_4(w4),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_last(out_last_a), .frame_done(frame_done_a),
`ifdef SER_IDX_EN
        .out_idx(idx_a),
`endif
        .busy(busy_a)
    );

    pool2_row_serializer #(.DATA_W(DW), .LEAD(LEAD_B), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst),
        .in_word_1(w1), .in_word_2(w2), .in_word_3(w3), .in_word_4(w4),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_last(out_last_b), .frame_done(frame_done_b),
`ifdef SER_IDX_EN
        .out_idx(idx_b),
`endif
        .busy(busy_b)
    );

`ifndef SER_IDX_EN
    assign idx_a = 2'b00;
    assign idx_b = 2'b00;
`endif

    logic [BW-1:0] got_a, got_b;
    assign got_a = {in_ready_a, busy_a, frame_done_a, out_last_a, out_valid_a, idx_a, out_data_a};
    assign got_b = {in_ready_b, busy_b, frame_done_b, out_last_b, out_valid_b, idx_b, out_data_b};

    // Reference model: a held frame, the number of words still owed, and the edge from
    // which the next word is due. Accept -> due after LEAD edges; handshake -> due after GAP.
    int            cyc = 0;
    logic [DW-1:0] mfr [2][4];
    int            rem [2] = '{0, 0};
    int            due [2] = '{0, 0};
    logic          exp_ready [2] = '{1'b0, 1'b0};
    logic          exp_valid [2] = '{1'b0, 1'b0};
    logic          exp_done  [2] = '{1'b0, 1'b0};
    logic [BW-1:0] exp_b [2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            logic          hs_out;
            logic          acc;
            logic [1:0]    eidx;
            logic [DW-1:0] edata;
            hs_out = exp_valid[i] && out_ready;
            acc    = in_valid && exp_ready[i];
            exp_done[i] = 1'b0;
            if (rst) begin
                rem[i]       = 0;
                exp_ready[i] = 1'b0;
            end else begin
                if (hs_out) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) exp_done[i] = 1'b1;
                    else due[i] = cyc + ((i == 0) ? GAP_A : GAP_B);
                end
                if (acc) begin
                    mfr[i][0] = w1;
                    mfr[i][1] = w2;
                    mfr[i][2] = w3;
                    mfr[i][3] = w4;
                    rem[i] = 4;
                    due[i] = cyc + ((i == 0) ? LEAD_A : LEAD_B);
                end
                exp_ready[i] = (rem[i] == 0);
            end
            exp_valid[i] = (rem[i] > 0) && (cyc >= due[i]);
            eidx  = 2'b00;
            edata = '0;
            if (exp_valid[i]) begin
                edata = mfr[i][4 - rem[i]];
`ifdef SER_IDX_EN
                eidx = 2'(4 - rem[i]);
`endif
            end
            exp_b[i] = {exp_ready[i], (rem[i] > 0), exp_done[i],
                        (exp_valid[i] && rem[i] == 1), exp_valid[i], eidx, edata};
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 32; k++) begin
            r = {r[DW-33:0], 32'($urandom)};
        end
        return r;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(exp_ready[0] && exp_ready[1]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(exp_ready[0] && exp_ready[1])) begin
            errors++;
            $display("[TB] FAIL %s_idle_timeout waited=%0d cycles, need both idle", tag, n);
        end
    endtask

    task automatic test_reset();
        $display("[TB] reset values");
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (got_a !== '0) begin
                errors++;
                $display("[TB] FAIL reset_a got=%h need=0", got_a);
            end
            checks++;
            if (got_b !== '0) begin
                errors++;
                $display("[TB] FAIL reset_b got=%h need=0", got_b);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready_a, in_ready_b, busy_a, busy_b} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL reset_release ready/busy=%b need=1100", {in_ready_a, in_ready_b, busy_a, busy_b});
        end
    endtask

    task automatic test_basic();
        int va[$];
        int vb[$];
        int da = -1;
        int db = -1;
        int want_a[4] = '{0, 3, 6, 9};
        int want_b[4] = '{4, 5, 6, 7};
        $display("[TB] basic frame with fixed patterns");
        wait_idle("basic");
        out_ready = 1'b1;
        w1 = {7{32'hA1A2A3A4}};
        w2 = {7{32'hB5B6B7B8}};
        w3 = {7{32'hC9CACBCC}};
        w4 = {7{32'hDDDEDFD0}};
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (got_a !== exp_b[0]) begin
                errors++;
                $display("[TB] FAIL basic_a c=%0d got=%h exp=%h", c, got_a, exp_b[0]);
            end
            checks++;
            if (got_b !== exp_b[1]) begin
                errors++;
                $display("[TB] FAIL basic_b c=%0d got=%h exp=%h", c, got_b, exp_b[1]);
            end
            if (out_valid_a === 1'b1) va.push_back(c);
            if (out_valid_b === 1'b1) vb.push_back(c);
            if (frame_done_a === 1'b1) da = c;
            if (frame_done_b === 1'b1) db = c;
        end
        checks++;
        if (va.size() != 4 || vb.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_beats a=%0d b=%0d need 4 each", va.size(), vb.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (va[k] != want_a[k] || vb[k] != want_b[k]) begin
                    errors++;
                    $display("[TB] FAIL basic_timing beat%0d a=%0d b=%0d need %0d/%0d", k, va[k], vb[k], want_a[k], want_b[k]);
                end
            end
        end
        checks++;
        if (da != 10 || db != 8) begin
            errors++;
            $display("[TB] FAIL basic_done a=%0d b=%0d need 10/8", da, db);
        end
    endtask

    task automatic test_stall();
        $display("[TB] stall on word 2");
        wait_idle("stall");
        out_ready = 1'b1;
        w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word(); w4 = rnd_word();
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            w1 = rnd_word();
            checks++;
            if (got_a !== exp_b[0]) begin
                errors++;
                $display("[TB] FAIL stall_a c=%0d got=%h exp=%h", c, got_a, exp_b[0]);
            end
            checks++;
            if (got_b !== exp_b[1]) begin
                errors++;
                $display("[TB] FAIL stall_b c=%0d got=%h exp=%h", c, got_b, exp_b[1]);
            end
            out_ready = !(c >= 2 && c < 7);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        $display("[TB] reset during gap");
        wait_idle("rmid");
        out_ready = 1'b1;
        w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word(); w4 = rnd_word();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (got_a !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_a got=%h need=0", got_a);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (got_a !== exp_b[0]) begin
                errors++;
                $display("[TB] FAIL rmid_after_a c=%0d got=%h exp=%h", c, got_a, exp_b[0]);
            end
        end
        wait_idle("rmid2");
        w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word(); w4 = rnd_word();
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (got_a !== exp_b[0]) begin
                errors++;
                $display("[TB] FAIL rmid_fresh_a c=%0d got=%h exp=%h", c, got_a, exp_b[0]);
            end
            checks++;
            if (got_b !== exp_b[1]) begin
                errors++;
                $display("[TB] FAIL rmid_fresh_b c=%0d got=%h exp=%h", c, got_b, exp_b[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int frames_a = 0;
        $display("[TB] random traffic, in_valid while busy, changing inputs");
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word(); w4 = rnd_word();
            @(negedge clk);
            checks++;
            if (got_a !== exp_b[0]) begin
                errors++;
                $display("[TB] FAIL b2b_a c=%0d got=%h exp=%h", c, got_a, exp_b[0]);
            end
            checks++;
            if (got_b !== exp_b[1]) begin
                errors++;
                $display("[TB] FAIL b2b_b c=%0d got=%h exp=%h", c, got_b, exp_b[1]);
            end
            if (exp_done[0]) frames_a++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (frames_a < 5) begin
            errors++;
            $display("[TB] FAIL b2b_progress frames=%0d need>=5", frames_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool2_row_serializer.md
Name: pool2_row_serializer

Overview:
- Opposite direction of the conv2→pool2 demux. It accepts four parallel DATA_W-bit row words in a single handshake and replays them one word at a time onto a single DATA_W-bit bus.
- Words leave at a fixed, programmable cadence with valid/ready flow control.
- It sits between pooling-stage result registers and downstream consumers that take one row per beat, such as the FC/next-layer input stage.

Parameters:
- DATA_W, 224, width of each row word and of the output bus.
- LEAD, 0, idle cycles inserted between frame acceptance and the first word (0..255).
- GAP, 2, idle cycles inserted after each accepted word before the next word becomes valid (0..255). GAP=2 gives the 3-cycle row spacing used by pool2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_word_1  input  DATA_W  frame word 0, sent first
- in_word_2  input  DATA_W  frame word 1
- in_word_3  input  DATA_W  frame word 2
- in_word_4  input  DATA_W  frame word 3, sent last
- in_valid  input  1  the four input words are valid
- in_ready  output  1  block can accept a frame
- out_data  output  DATA_W  current word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_last  output  1  high with the fourth word of a frame
- frame_done  output  1  one-cycle pulse after the fourth word is accepted
- busy  output  1  a frame is held and not yet fully sent

Behaviour:
- Reset and clocking:
  - Clock is clk. Reset is rst, synchronous and active-high; it is sampled only on the rising edge of clk.
  - All outputs are registered.
  - Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0, busy=0. The word buffer is cleared and the FSM goes to IDLE.
  - in_ready rises on the first clock after rst deasserts.
- FSM states: IDLE, LEAD, SEND, GAP. A 2-bit idx selects the buffered word; an 8-bit cnt times the LEAD and GAP states.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - in_valid&in_ready at edge t: latch in_word_1..4 into buf[0..3], set idx=0, and drop in_ready.
  - If LEAD>0: go to LEAD with cnt=LEAD-1.
  - If LEAD==0: go to SEND, with out_valid=1 and out_data=buf[0] visible in cycle t+1.
- LEAD:
  - Decrement cnt each cycle.
  - When cnt==0, go to SEND. The first word is therefore valid LEAD+1 cycles after the input handshake.
- SEND:
  - out_valid=1, out_data=buf[idx], out_last=(idx==3).
  - Holds stable while out_ready=0, for any number of cycles.
  - On out_valid&out_ready at edge t:
    - If idx==3: go to IDLE. frame_done=1 for cycle t+1 only. in_ready=1 from t+1.
    - Else: idx++. If GAP==0, the next word is valid at t+1 (back-to-back). If GAP>0, go to GAP with cnt=GAP-1.
- GAP:
  - out_valid=0, out_data=0, out_last=0.
  - When cnt==0, go to SEND. The next word is valid GAP+1 cycles after the previous handshake.
- out_data is forced to 0 whenever out_valid=0.
- busy=1 in LEAD, SEND and GAP.
- in_valid while busy is ignored. No frame is queued and the buffer is not overwritten.
- Changes on in_word_* after acceptance do not affect the output.
- Reset asserted mid-frame aborts at that edge: remaining words are discarded, no frame_done is produced, and all outputs take their reset values.
- A new frame may be accepted no earlier than the cycle frame_done is high. There is no overlap with the previous frame.
- No arithmetic is performed on the data; it passes through bit-exact.

Optional Feature:
- Macro SER_IDX_EN.
- Defined: adds output port out_idx [1:0], equal to idx while out_valid=1 and 0 otherwise. It resets to 0.
- Not defined: the port is absent; behaviour is otherwise identical.

Test Plan:
- LEAD=0, GAP=2, out_ready held 1, frame words 0xA..,0xB..,0xC..,0xD.. (distinct patterns across all 224 bits) -> words valid at cycles t+1, t+4, t+7, t+10 in order. out_last only at t+10. frame_done at t+11. in_ready back at t+11.
- Same frame, out_ready=0 for 5 cycles on word 2 -> out_data/out_valid stable through the stall. Word 3 valid GAP+1 cycles after the delayed handshake. No word lost or duplicated.
- LEAD=4, GAP=0 -> first word at t+5, then four consecutive beats. out_last on the fourth beat.
- in_valid pulsed with new data while busy, and in_word_* changed after acceptance -> output sequence equals the originally latched frame. The second frame is accepted only after frame_done.
- rst asserted during GAP after word 1 -> next cycle all outputs at reset values, no frame_done. After release, a fresh frame serializes from word 0.
- With SER_IDX_EN defined -> out_idx = 0,1,2,3 aligned with each valid beat, and 0 in GAP/IDLE.
